imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter IDX_W, default 4: instruction-memory index width; memory depth is 2^IDX_W = 16 words.
REQ-002 SHALL have parameter MAX_LOAD_RUN, default 4: maximum consecutive load grants while a fetch is pending.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port fetch_req, input, 1: fetch request, held until fetch_valid.
REQ-006 SHALL have port fetch_addr, input, 16: byte PC; word index is fetch_addr[IDX_W:1].
REQ-007 SHALL have port fetch_valid, output, 1: one-cycle fetch completion pulse.
REQ-008 SHALL have port fetch_data, output, 16: fetched instruction, valid while fetch_valid=1.
REQ-009 SHALL have port fetch_err, output, 1: out-of-range fetch flag, coincident with fetch_valid.
REQ-010 SHALL have port load_req, input, 1: program-load write request, held until load_ack.
REQ-011 SHALL have port load_addr, input, 16: byte address of the word to write.
REQ-012 SHALL have port load_data, input, 16: word to write.
REQ-013 SHALL have port load_ack, output, 1: one-cycle load completion pulse.
REQ-014 SHALL have port load_err, output, 1: out-of-range load flag, coincident with load_ack.
REQ-015 SHALL have port mem_addr, output, IDX_W: memory word index.
REQ-016 SHALL have port mem_we, output, 1: memory write enable.
REQ-017 SHALL have port mem_wdata, output, 16: memory write data.
REQ-018 SHALL have port mem_rdata, input, 16: combinational memory read data for mem_addr.
REQ-019 SHALL have port busy, output, 1: high when state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH_RD, LOAD_WR; all outputs registered.
REQ-021 SHALL sample fetch_req/load_req only in IDLE; requests arriving in other states wait.
REQ-022 IDLE arbitration SHALL be: load only -> LOAD_WR; fetch only -> FETCH_RD; both -> LOAD_WR unless load_run == MAX_LOAD_RUN, then FETCH_RD; neither -> stay IDLE.
REQ-023 SHALL maintain a load_run counter: increments on each load grant, saturating at MAX_LOAD_RUN; clears on a fetch grant or on any IDLE cycle with load_req=0.
REQ-024 On fetch grant SHALL register mem_addr <= fetch_addr[IDX_W:1] and mem_we <= 0.
REQ-025 In FETCH_RD SHALL capture fetch_data <= mem_rdata, pulse fetch_valid for one cycle, and return to IDLE; fetch latency is 2 cycles from the sampling edge.
REQ-026 On load grant SHALL register mem_addr <= load_addr[IDX_W:1], mem_wdata <= load_data, and mem_we <= 1 for exactly one cycle (the LOAD_WR cycle).
REQ-027 In LOAD_WR SHALL drive mem_we to 0 at the next edge, pulse load_ack for one cycle, and return to IDLE.
REQ-028 An address with any bit in [15:IDX_W+1] set SHALL be out of range; bit 0 SHALL be ignored.
REQ-029 An out-of-range fetch SHALL return fetch_data=16'h0000 with fetch_err=1.
REQ-030 An out-of-range load SHALL keep mem_we=0 and return load_ack with load_err=1.
REQ-031 A request still high in the IDLE cycle following its ack SHALL be treated as a new request; back-to-back operation SHALL sustain one access per 2 cycles.
REQ-032 fetch_data SHALL hold its last value between fetches.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, load_run=0, and all outputs to 0, including mem_we, independent of clk.
REQ-034 Reset asserted during LOAD_WR SHALL abort the write with no load_ack; reset asserted during FETCH_RD SHALL produce no fetch_valid.
REQ-035 After rst_n deasserts, the first request SHALL be sampled at the first rising clk edge at which rst_n=1.

Verification
REQ-036 Fetch: fetch_addr=16'h0006, with mem word 3=16'h1234 -> fetch_valid=1 and fetch_data=16'h1234 2 cycles later, fetch_err=0.
REQ-037 Load: load_addr=16'h000A, load_data=16'hBEEF -> mem_we=1 for one cycle with mem_addr=5 and mem_wdata=16'hBEEF; load_ack follows.
REQ-038 Fairness: load_req and fetch_req both held high -> grant order L,L,L,L,F,L,... with MAX_LOAD_RUN=4.
REQ-039 Range: fetch_addr=16'h0040 -> fetch_err=1 and fetch_data=0; load_addr=16'h0100 -> load_err=1 and mem_we never asserted.
REQ-040 Reset mid-write: rst_n low during LOAD_WR -> mem_we=0 immediately, no load_ack, busy=0.

Source files
------------

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: shares one single-port IMEM between
// the fetch unit and the program loader, bounding load runs ahead of fetch.
module imem_arbiter #(
    parameter int IDX_W        = 4,
    parameter int MAX_LOAD_RUN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_req,
    input  logic [15:0]      fetch_addr,
    output logic             fetch_valid,
    output logic [15:0]      fetch_data,
    output logic             fetch_err,
    input  logic             load_req,
    input  logic [15:0]      load_addr,
    input  logic [15:0]      load_data,
    output logic             load_ack,
    output logic             load_err,
    output logic [IDX_W-1:0] mem_addr,
    output logic             mem_we,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    output logic             busy
);

    localparam int RUN_W = $clog2(MAX_LOAD_RUN + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_RD,
        LOAD_WR
    } state_e;

    state_e           state_q, state_d;
    logic [RUN_W-1:0] load_run_q, load_run_d;
    logic             oor_q, oor_d;

    logic             fetch_valid_q, fetch_valid_d;
    logic [15:0]      fetch_data_q, fetch_data_d;
    logic             fetch_err_q, fetch_err_d;
    logic             load_ack_q, load_ack_d;
    logic             load_err_q, load_err_d;
    logic [IDX_W-1:0] mem_addr_q, mem_addr_d;
    logic             mem_we_q, mem_we_d;
    logic [15:0]      mem_wdata_q, mem_wdata_d;
    logic             busy_q, busy_d;

    logic fetch_oor;
    logic load_oor;
    logic run_full;
    logic grant_load;
    logic grant_fetch;
    logic unused_bits;

    // Byte addresses: bit 0 is don't-care, anything above the index is out of range.
    assign fetch_oor   = |fetch_addr[15:IDX_W+1];
    assign load_oor    = |load_addr[15:IDX_W+1];
    assign unused_bits = ^{fetch_addr[0], load_addr[0]};

    assign run_full    = (load_run_q == RUN_W'(MAX_LOAD_RUN));
    assign grant_load  = load_req && (!fetch_req || !run_full);
    assign grant_fetch = fetch_req && !grant_load;

    always_comb begin
        state_d       = state_q;
        load_run_d    = load_run_q;
        oor_d         = oor_q;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        fetch_err_d   = 1'b0;
        load_ack_d    = 1'b0;
        load_err_d    = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = 1'b0;
        mem_wdata_d   = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_load) begin
                    state_d     = LOAD_WR;
                    oor_d       = load_oor;
                    mem_addr_d  = load_addr[IDX_W:1];
                    mem_wdata_d = load_data;
                    mem_we_d    = !load_oor;
                    if (!run_full) begin
                        load_run_d = load_run_q + RUN_W'(1);
                    end
                end else if (grant_fetch) begin
                    state_d    = FETCH_RD;
                    oor_d      = fetch_oor;
                    mem_addr_d = fetch_addr[IDX_W:1];
                    load_run_d = '0;
                end else begin
                    load_run_d = '0;
                end
            end
            FETCH_RD: begin
                state_d       = IDLE;
                fetch_valid_d = 1'b1;
                fetch_err_d   = oor_q;
                fetch_data_d  = oor_q ? 16'h0000 : mem_rdata;
            end
            LOAD_WR: begin
                state_d    = IDLE;
                load_ack_d = 1'b1;
                load_err_d = oor_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            load_run_q    <= '0;
            oor_q         <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            fetch_err_q   <= 1'b0;
            load_ack_q    <= 1'b0;
            load_err_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_run_q    <= load_run_d;
            oor_q         <= oor_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_err_q   <= fetch_err_d;
            load_ack_q    <= load_ack_d;
            load_err_q    <= load_err_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            busy_q        <= busy_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_err   = fetch_err_q;
    assign load_ack    = load_ack_q;
    assign load_err    = load_err_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_imem_arbiter;

    localparam int MAX_RUN = 4;
    localparam int RANGE   = 32;

    localparam logic [15:0] INIT [16] = '{
        16'h0A01, 16'h1B02, 16'h2C03, 16'h1234,
        16'h3D04, 16'h4E05, 16'h5F06, 16'h6A07,
        16'h7B08, 16'h8C09, 16'h9D0A, 16'hAE0B,
        16'hBF0C, 16'hC00D, 16'hD10E, 16'hE20F
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_valid;
    logic [15:0] fetch_data;
    logic        fetch_err;
    logic        load_req;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic        load_ack;
    logic        load_err;
    logic [3:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_arbiter #(
        .IDX_W       (4),
        .MAX_LOAD_RUN(MAX_RUN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_err  (fetch_err),
        .load_req   (load_req),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ack   (load_ack),
        .load_err   (load_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    // Physical memory seen by the DUT.
    logic [15:0] mem [16] = INIT;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction at a time.
    logic [15:0] refm [16] = INIT;
    bit          m_active = 0;
    bit          m_is_load = 0;
    bit          m_oor = 0;
    int          m_idx = 0;
    logic [15:0] m_wd = 0;
    int          m_run = 0;
    logic        e_fv = 0, e_fe = 0, e_la = 0, e_le = 0, e_we = 0, e_busy = 0;
    logic [15:0] e_fd = 0, e_wd = 0;
    logic [3:0]  e_ma = 0;

    initial begin : monitor
        logic        r, fr, lr;
        logic [15:0] fa, la, ld;
        forever begin
            @(posedge clk);
            r = rst_n; fr = fetch_req; lr = load_req;
            fa = fetch_addr; la = load_addr; ld = load_data;
            e_fv = 0; e_fe = 0; e_la = 0; e_le = 0; e_we = 0;
            if (!r) begin
                m_active = 0; m_run = 0; e_busy = 0;
                e_fd = 0; e_wd = 0; e_ma = 0;
            end else if (!m_active) begin
                if (lr && (!fr || m_run < MAX_RUN)) begin
                    m_active = 1; m_is_load = 1;
                    m_oor = (la >= RANGE);
                    m_idx = (la / 2) % 16;
                    m_wd = ld;
                    e_ma = 4'(m_idx); e_wd = ld; e_we = !m_oor;
                    m_run = (m_run < MAX_RUN) ? m_run + 1 : MAX_RUN;
                    e_busy = 1;
                end else if (fr) begin
                    m_active = 1; m_is_load = 0;
                    m_oor = (fa >= RANGE);
                    m_idx = (fa / 2) % 16;
                    e_ma = 4'(m_idx);
                    m_run = 0;
                    e_busy = 1;
                end else begin
                    m_run = 0;
                    e_busy = 0;
                end
            end else begin
                m_active = 0; e_busy = 0;
                if (m_is_load) begin
                    e_la = 1; e_le = m_oor;
                    if (!m_oor) refm[m_idx] = m_wd;
                end else begin
                    e_fv = 1; e_fe = m_oor;
                    e_fd = m_oor ? 16'h0000 : refm[m_idx];
                end
            end
            #1;
            chk("m_fetch_valid", fetch_valid, e_fv);
            chk("m_fetch_err", fetch_err, e_fe);
            chk("m_fetch_data", fetch_data, e_fd);
            chk("m_load_ack", load_ack, e_la);
            chk("m_load_err", load_err, e_le);
            chk("m_mem_we", mem_we, e_we);
            chk("m_mem_addr", mem_addr, e_ma);
            chk("m_mem_wdata", mem_wdata, e_wd);
            chk("m_busy", busy, e_busy);
        end
    end

    task automatic fetch_op(input logic [15:0] a, output logic [15:0] d,
                            output logic e);
        bit got = 0;
        d = 0; e = 0;
        @(negedge clk);
        fetch_addr = a; fetch_req = 1;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            if (fetch_valid) begin
                got = 1; d = fetch_data; e = fetch_err;
            end
        end
        chk("fetch_done", got, 1);
        @(negedge clk);
        fetch_req = 0;
    endtask

    task automatic load_op(input logic [15:0] a, input logic [15:0] d,
                           output logic e, output logic saw_we);
        bit got = 0;
        e = 0; saw_we = 0;
        @(negedge clk);
        load_addr = a; load_data = d; load_req = 1;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            if (mem_we) saw_we = 1;
            if (load_ack) begin
                got = 1; e = load_err;
            end
        end
        chk("load_done", got, 1);
        @(negedge clk);
        load_req = 0;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r[15:0];
        return 16'($urandom_range(0, RANGE - 1));
    endfunction

    initial begin : stim
        logic [15:0] d;
        logic        e, we;
        string       seq;
        int          rst_cnt;

        rst_n = 0; fetch_req = 0; load_req = 0;
        fetch_addr = 0; load_addr = 0; load_data = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_load_ack", load_ack, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        fetch_addr = 16'h0006; fetch_req = 1;
        @(posedge clk); #1;
        chk("f_e0_busy", busy, 1);
        chk("f_e0_valid", fetch_valid, 0);
        chk("f_e0_addr", mem_addr, 3);
        @(posedge clk); #1;
        chk("f_valid", fetch_valid, 1);
        chk("f_data", fetch_data, 16'h1234);
        chk("f_err", fetch_err, 0);
        @(negedge clk);
        fetch_req = 0;

        load_addr = 16'h000A; load_data = 16'hBEEF; load_req = 1;
        @(posedge clk); #1;
        chk("l_we", mem_we, 1);
        chk("l_addr", mem_addr, 5);
        chk("l_wdata", mem_wdata, 16'hBEEF);
        chk("l_ack_early", load_ack, 0);
        @(posedge clk); #1;
        chk("l_we_off", mem_we, 0);
        chk("l_ack", load_ack, 1);
        chk("l_err", load_err, 0);
        @(negedge clk);
        load_req = 0;

        fetch_op(16'h000B, d, e);
        chk("rb_data", d, 16'hBEEF);

        fetch_op(16'h0040, d, e);
        chk("oor_f_err", e, 1);
        chk("oor_f_data", d, 0);
        load_op(16'h0100, 16'hDEAD, e, we);
        chk("oor_l_err", e, 1);
        chk("oor_l_we", we, 0);

        @(negedge clk);
        fetch_addr = 16'h0006; load_addr = 16'h000C;
        load_data = 16'h5A5A;
        fetch_req = 1; load_req = 1;
        seq = "";
        for (int k = 0; k < 60 && seq.len() < 10; k++) begin
            @(posedge clk); #1;
            if (load_ack) seq = {seq, "L"};
            if (fetch_valid) seq = {seq, "F"};
        end
        n_chk++;
        if (seq != "LLLLFLLLLF") begin
            n_fail++;
            $display("FAIL fairness: got %s expected LLLLFLLLLF", seq);
        end
        @(negedge clk);
        fetch_req = 0; load_req = 0;
        @(negedge clk);

        load_addr = 16'h0004; load_data = 16'h7777; load_req = 1;
        @(posedge clk); #1;
        chk("mw_we", mem_we, 1);
        #2 rst_n = 0;
        #1;
        chk("mw_we_rst", mem_we, 0);
        chk("mw_busy_rst", busy, 0);
        chk("mw_ack_rst", load_ack, 0);
        @(negedge clk);
        load_req = 0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("mw_no_ack", load_ack, 0);
        end
        @(negedge clk);
        rst_n = 1;
        fetch_addr = 16'h0004; fetch_req = 1;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 1);
        @(posedge clk); #1;
        chk("post_rst_valid", fetch_valid, 1);
        chk("post_rst_data", fetch_data, INIT[2]);
        @(negedge clk);
        fetch_req = 0;

        fetch_addr = 16'h0008; fetch_req = 1;
        @(posedge clk); #1;
        #2 rst_n = 0;
        #1;
        chk("mf_busy_rst", busy, 0);
        @(negedge clk);
        fetch_req = 0;
        @(posedge clk); #1;
        chk("mf_no_valid", fetch_valid, 0);
        @(negedge clk);
        rst_n = 1;

        rst_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst_n = 1;
                continue;
            end
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 0; rst_cnt = $urandom_range(1, 3);
                fetch_req = 0; load_req = 0;
                continue;
            end
            if (fetch_req) begin
                if (fetch_valid) begin
                    if ($urandom_range(0, 3) != 0) fetch_req = 0;
                    else fetch_addr = rand_addr();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                fetch_req = 1; fetch_addr = rand_addr();
            end
            if (load_req) begin
                if (load_ack) begin
                    if ($urandom_range(0, 3) != 0) begin
                        load_req = 0;
                    end else begin
                        load_addr = rand_addr();
                        load_data = 16'($urandom);
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                load_req = 1; load_addr = rand_addr();
                load_data = 16'($urandom);
            end
        end

        @(negedge clk);
        rst_n = 1; fetch_req = 0; load_req = 0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
